game_status_keeper: RTL and testbench

- Bookkeeping stage that sits directly around the game controller.
- Consumes the controller's event outputs: decreaseLife, raiseScore and nextLevel.
- Produces the remainingLives and timeUp inputs the controller reads, plus score, level, seconds-left and win/over status for the HUD/VGA digit drawers.
- Owns the per-level countdown timer and the end-of-level time-bonus tally.

---
 rtl/game_status_pkg.sv | 29 ++
 rtl/level_countdown.sv | 64 ++++++
 rtl/game_status_keeper.sv | 196 +++++++++++++++++++
 tb/tb_game_status_keeper.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_status_pkg.sv
// game_status_pkg: shared types and constants for the game status keeper.
// The top module's optional bonus-life logic is controlled by the macro
// GAME_STATUS_BONUS_LIFE_EN; nothing in this package depends on it.
package game_status_pkg;

   // Bookkeeping FSM: normal play, end-of-level time tally, and the two
   // terminal states.
   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_TALLY = 2'd1,
      ST_OVER  = 2'd2,
      ST_WON   = 2'd3
   } status_state_t;

   // Score register width; the score port and all score arithmetic use it.
   localparam int SCORE_W = 16;

   // Score distance between two bonus lives.
   localparam int BONUS_STEP = 1000;

   typedef logic [3:0] lives_t;
   typedef logic [6:0] secs_t;

   // Seconds counter decrement that sticks at zero.
   function automatic secs_t decSat(input secs_t s);
      return (s == '0) ? s : s - 7'd1;
   endfunction

endpackage

// File: rtl/level_countdown.sv
// level_countdown: per-level countdown timer.
// A frame divider turns startOfFrame pulses into one-second ticks while
// `run` is high. `reload` restarts the level time and clears the divider,
// `tallyStep` removes one second during the end-of-level tally, and
// timeUp is the registered "countdown at zero while in play" flag.
module level_countdown
   import game_status_pkg::*;
#(
   parameter int LEVEL_TIME_SEC = 99,
   parameter int FRAMES_PER_SEC = 30
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       run,
   input  logic       reload,
   input  logic       tallyStep,
   input  logic       inPlay,
   output logic [6:0] secondsLeft,
   output logic       secTick,
   output logic       timeUp
);

   localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);
   localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
   localparam secs_t RELOAD_SECS = secs_t'(LEVEL_TIME_SEC);

   logic [FC_W-1:0] frameCnt;

   // A second elapses on the frame that wraps the divider.
   assign secTick = run && startOfFrame && (frameCnt == FC_LAST);

   // Divider and seconds register; a reload beats both the tick and the
   // tally step, and the divider only moves while running.
   always_ff @(posedge clk) begin
      if (reset) begin
         frameCnt    <= '0;
         secondsLeft <= RELOAD_SECS;
      end else if (reload) begin
         frameCnt    <= '0;
         secondsLeft <= RELOAD_SECS;
      end else if (tallyStep) begin
         secondsLeft <= decSat(secondsLeft);
      end else if (run && startOfFrame) begin
         if (secTick) begin
            frameCnt    <= '0;
            secondsLeft <= decSat(secondsLeft);
         end else begin
            frameCnt <= frameCnt + FC_ONE;
         end
      end
   end

   // timeUp follows secondsLeft==0 one cycle later, only during play.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeUp <= 1'b0;
      end else begin
         timeUp <= inPlay && (secondsLeft == '0);
      end
   end

endmodule

// File: rtl/game_status_keeper.sv
// game_status_keeper: lives, score, level and win/lose bookkeeping around
// the game controller, plus the per-level countdown (level_countdown).
// Optional feature macro: GAME_STATUS_BONUS_LIFE_EN grants one extra life
// each time the score crosses a multiple of 1000 (capped at MAX_LIVES).
//
// Controller interface: decreaseLife and raiseScore are single-cycle
// pulses acted on in the cycle they are high (no handshake, no
// backpressure); nextLevel is a level signal of which only the rising
// edge matters. dbgState mirrors the FSM state for observation.
module game_status_keeper
   import game_status_pkg::*;
#(
   parameter int INIT_LIVES     = 3,
   parameter int MAX_LIVES      = 9,
   parameter int LEVEL_TIME_SEC = 99,
   parameter int FRAMES_PER_SEC = 30,
   parameter int DIAMOND_POINTS = 10,
   parameter int TIME_BONUS     = 5,
   parameter int NUM_LEVELS     = 3
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               timerEnable,
   input  logic               decreaseLife,
   input  logic               raiseScore,
   input  logic               nextLevel,
   output logic [3:0]         remainingLives,
   output logic               timeUp,
   output logic [6:0]         secondsLeft,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         level,
   output logic               levelStart,
   output logic               gameOver,
   output logic               gameWon,
   output logic [1:0]         dbgState,
   output logic               dbgSecTick
);

   localparam lives_t             INIT_L      = lives_t'(INIT_LIVES);
   localparam lives_t             MAX_L       = lives_t'(MAX_LIVES);
   localparam logic [SCORE_W-1:0] DIAMOND_ADD = SCORE_W'(DIAMOND_POINTS);
   localparam logic [SCORE_W-1:0] TALLY_ADD   = SCORE_W'(TIME_BONUS);
   localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
   localparam logic [1:0]         LAST_LEVEL  = 2'(NUM_LEVELS - 1);

   status_state_t      state;
   status_state_t      stateNext;
   logic               nextLevelQ;
   logic               nlEdge;
   logic               inPlay;
   logic               inTally;
   logic               run;
   logic               reload;
   logic               tallyStep;
   logic               lifeLost;
   logic               goOver;
   logic               levelUp;
   logic               enterWon;
   logic               scoreUpd;
   logic               bonusLife;
   logic               secTick;
   logic [SCORE_W-1:0] scoreAdd;
   logic [SCORE_W-1:0] scoreNext;
   logic [SCORE_W:0]   scoreSum;
   lives_t             livesNext;

   assign inPlay   = (state == ST_PLAY);
   assign inTally  = (state == ST_TALLY);
   assign nlEdge   = nextLevel && !nextLevelQ;
   assign run      = inPlay && timerEnable;
   assign lifeLost = inPlay && decreaseLife;

   // Tally: one second converted to bonus points per frame until empty,
   // then either advance the level or finish the game.
   assign tallyStep = inTally && (secondsLeft != '0) && startOfFrame;
   assign levelUp   = inTally && (secondsLeft == '0) && (level != LAST_LEVEL);
   assign enterWon  = inTally && (secondsLeft == '0) && (level == LAST_LEVEL);
   assign reload    = lifeLost || levelUp;

   // Score is only touched by diamonds in play and by the tally steps;
   // the sum carries one extra bit so overflow clamps instead of wrapping.
   assign scoreUpd  = (inPlay && raiseScore) || tallyStep;
   assign scoreAdd  = inTally ? TALLY_ADD : DIAMOND_ADD;
   assign scoreSum  = {1'b0, score} + {1'b0, scoreAdd};
   assign scoreNext = !scoreUpd       ? score :
                      scoreSum[SCORE_W] ? SCORE_MAX : scoreSum[SCORE_W-1:0];

`ifdef GAME_STATUS_BONUS_LIFE_EN
   localparam logic [SCORE_W:0] BONUS_STEP_W = (SCORE_W + 1)'(BONUS_STEP);

   // Next score multiple that earns a life. Score never decreases and a
   // single update adds far less than BONUS_STEP, so one comparison per
   // update finds every crossing and at most one per cycle.
   logic [SCORE_W:0] bonusAt;

   assign bonusLife = scoreUpd && ({1'b0, scoreNext} >= bonusAt);

   // Advance the threshold each time a bonus life is granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         bonusAt <= BONUS_STEP_W;
      end else if (bonusLife) begin
         bonusAt <= bonusAt + BONUS_STEP_W;
      end
   end
`else
   assign bonusLife = 1'b0;
`endif

   // Lives: a bonus and a lost life in the same cycle cancel out.
   always_comb begin
      livesNext = remainingLives;
      if (bonusLife && !lifeLost) begin
         if (remainingLives < MAX_L) livesNext = remainingLives + 4'd1;
      end else if (lifeLost && !bonusLife) begin
         if (remainingLives != '0) livesNext = remainingLives - 4'd1;
      end
   end

   // Losing the last life outranks a simultaneous nextLevel edge.
   assign goOver = lifeLost && (livesNext == '0);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_PLAY;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic; the terminal states hold until reset.
   always_comb begin
      stateNext = state;
      case (state)
         ST_PLAY: begin
            if (goOver) begin
               stateNext = ST_OVER;
            end else if (nlEdge) begin
               stateNext = ST_TALLY;
            end
         end
         ST_TALLY: begin
            if (enterWon) begin
               stateNext = ST_WON;
            end else if (levelUp) begin
               stateNext = ST_PLAY;
            end
         end
         default: stateNext = state;
      endcase
   end

   // Bookkeeping registers; in the terminal states every update term is
   // zero so these simply hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         remainingLives <= INIT_L;
         score          <= '0;
         level          <= '0;
         levelStart     <= 1'b0;
         gameOver       <= 1'b0;
         gameWon        <= 1'b0;
         nextLevelQ     <= 1'b0;
      end else begin
         remainingLives <= livesNext;
         score          <= scoreNext;
         levelStart     <= levelUp;
         gameOver       <= gameOver || goOver;
         gameWon        <= gameWon || enterWon;
         nextLevelQ     <= nextLevel;
         if (levelUp) level <= level + 2'd1;
      end
   end

   level_countdown #(
      .LEVEL_TIME_SEC (LEVEL_TIME_SEC),
      .FRAMES_PER_SEC (FRAMES_PER_SEC)
   ) uCountdown (
      .clk          (clk),
      .reset        (reset),
      .startOfFrame (startOfFrame),
      .run          (run),
      .reload       (reload),
      .tallyStep    (tallyStep),
      .inPlay       (inPlay),
      .secondsLeft  (secondsLeft),
      .secTick      (secTick),
      .timeUp       (timeUp)
   );

   assign dbgState   = state;
   assign dbgSecTick = secTick;

endmodule

// File: tb/tb_game_status_keeper.sv
// Directed bench for game_status_keeper with a cycle-level reference
// model of the game rules, an every-cycle compare process and literal
// checks at the interesting points of each scenario.
module tb_game_status_keeper;
   import game_status_pkg::*;

   localparam int INIT_LIVES     = 3;
   localparam int MAX_LIVES      = 9;
   localparam int LEVEL_TIME_SEC = 99;
   localparam int FRAMES_PER_SEC = 30;
   localparam int DIAMOND_POINTS = 10;
   localparam int TIME_BONUS     = 5;
   localparam int NUM_LEVELS     = 3;
   localparam int SCORE_LIMIT    = 65535;

   localparam int PH_PLAY  = 0;
   localparam int PH_TALLY = 1;
   localparam int PH_OVER  = 2;
   localparam int PH_WON   = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic startOfFrame = 1'b0;
   logic timerEnable = 1'b0;
   logic decreaseLife = 1'b0;
   logic raiseScore = 1'b0;
   logic nextLevel = 1'b0;

   logic [3:0]  remainingLives;
   logic        timeUp;
   logic [6:0]  secondsLeft;
   logic [15:0] score;
   logic [1:0]  level;
   logic        levelStart;
   logic        gameOver;
   logic        gameWon;
   logic [1:0]  dbgState;
   logic        dbgSecTick;

   always #5 clk = ~clk;

   game_status_keeper dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .timerEnable    (timerEnable),
      .decreaseLife   (decreaseLife),
      .raiseScore     (raiseScore),
      .nextLevel      (nextLevel),
      .remainingLives (remainingLives),
      .timeUp         (timeUp),
      .secondsLeft    (secondsLeft),
      .score          (score),
      .level          (level),
      .levelStart     (levelStart),
      .gameOver       (gameOver),
      .gameWon        (gameWon),
      .dbgState       (dbgState),
      .dbgSecTick     (dbgSecTick)
   );

   // ---------------- scoreboard counters ----------------
   int nVec = 0;
   int nMis = 0;

   function automatic void chk(input string name, input int act, input int exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   int mLives, mScore, mLevel, mSecs, mFrame, mPhase;
   int mTimeUp, mLevelStart, mOver, mWon, mPrevNl;
   int gain, newScore, ph;
   bit lost, bonus;
   bit modelValid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         mLives = INIT_LIVES; mScore = 0; mLevel = 0;
         mSecs = LEVEL_TIME_SEC; mFrame = 0; mPhase = PH_PLAY;
         mTimeUp = 0; mLevelStart = 0; mOver = 0; mWon = 0; mPrevNl = 0;
         modelValid = 1'b1;
      end else if (modelValid) begin
         ph = mPhase; gain = 0; lost = 1'b0; bonus = 1'b0;
         mTimeUp = (ph == PH_PLAY && mSecs == 0) ? 1 : 0;
         mLevelStart = 0;
         if (ph == PH_PLAY) begin
            if (timerEnable && startOfFrame) begin
               mFrame = mFrame + 1;
               if (mFrame == FRAMES_PER_SEC) begin
                  mFrame = 0;
                  if (mSecs > 0) mSecs = mSecs - 1;
               end
            end
            if (raiseScore) gain = DIAMOND_POINTS;
            if (decreaseLife) begin
               lost = 1'b1; mSecs = LEVEL_TIME_SEC; mFrame = 0;
            end
         end else if (ph == PH_TALLY) begin
            if (mSecs == 0) begin
               if (mLevel == NUM_LEVELS - 1) begin
                  mPhase = PH_WON; mWon = 1;
               end else begin
                  mLevel = mLevel + 1; mSecs = LEVEL_TIME_SEC; mFrame = 0;
                  mLevelStart = 1; mPhase = PH_PLAY;
               end
            end else if (startOfFrame) begin
               mSecs = mSecs - 1; gain = TIME_BONUS;
            end
         end
         newScore = mScore + gain;
         if (newScore > SCORE_LIMIT) newScore = SCORE_LIMIT;
`ifdef GAME_STATUS_BONUS_LIFE_EN
         bonus = (gain > 0) && (newScore / 1000 != mScore / 1000);
`endif
         mScore = newScore;
         if (lost && !bonus) begin
            if (mLives > 0) mLives = mLives - 1;
         end else if (bonus && !lost) begin
            if (mLives < MAX_LIVES) mLives = mLives + 1;
         end
         if (ph == PH_PLAY) begin
            if (lost && mLives == 0) begin
               mPhase = PH_OVER; mOver = 1;
            end else if (nextLevel && mPrevNl == 0) begin
               mPhase = PH_TALLY;
            end
         end
         mPrevNl = nextLevel ? 1 : 0;
      end
   end

   // ---------------- every-cycle compare ----------------
   int tickCnt = 0;

   always @(negedge clk) begin
      if (dbgSecTick) tickCnt = tickCnt + 1;
      if (modelValid) begin
         chk("remainingLives", int'(remainingLives), mLives);
         chk("timeUp",         int'(timeUp),         mTimeUp);
         chk("secondsLeft",    int'(secondsLeft),    mSecs);
         chk("score",          int'(score),          mScore);
         chk("level",          int'(level),          mLevel);
         chk("levelStart",     int'(levelStart),     mLevelStart);
         chk("gameOver",       int'(gameOver),       mOver);
         chk("gameWon",        int'(gameWon),        mWon);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input bit sof, input bit dec, input bit rs);
      startOfFrame = sof; decreaseLife = dec; raiseScore = rs;
      @(posedge clk); #1;
      startOfFrame = 1'b0; decreaseLife = 1'b0; raiseScore = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   int tickBase;
   int expLivesWon;

   initial begin
      // Reset values
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_lives", int'(remainingLives), 3);
      chk("rst_score", int'(score), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_secs",  int'(secondsLeft), 99);
      chk("rst_timeUp", int'(timeUp), 0);
      chk("rst_over",  int'(gameOver), 0);
      chk("rst_state", int'(dbgState), int'(ST_PLAY));

      // One second of frames
      timerEnable = 1'b1;
      tickBase = tickCnt;
      frames(30);
      chk("sec_secs",  int'(secondsLeft), 98);
      chk("sec_ticks", tickCnt - tickBase, 1);
      chk("sec_score", int'(score), 0);
      chk("sec_lives", int'(remainingLives), 3);

      // Run the countdown to zero; timeUp lags by a cycle
      frames(2939);
      step(1'b1, 1'b0, 1'b0);
      chk("zero_secs", int'(secondsLeft), 0);
      chk("zero_timeUp_lag", int'(timeUp), 0);
      step(1'b0, 1'b0, 1'b0);
      chk("zero_timeUp", int'(timeUp), 1);
      step(1'b0, 1'b1, 1'b0);
      chk("dec_lives", int'(remainingLives), 2);
      chk("dec_secs",  int'(secondsLeft), 99);
      step(1'b0, 1'b0, 1'b0);
      chk("dec_timeUp_clr", int'(timeUp), 0);

      // Diamonds, coincident life loss, saturation
      doReset();
      timerEnable = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("coin_score", int'(score), 30);
      chk("coin_lives", int'(remainingLives), 2);
      for (int i = 0; i < 6550; i++) step(1'b0, 1'b0, 1'b1);
      chk("pre_sat_score", int'(score), 65530);
      step(1'b0, 1'b0, 1'b1);
      chk("sat_score", int'(score), 65535);
      step(1'b0, 1'b0, 1'b1);
      chk("sat_hold", int'(score), 65535);

      // Level advance through the tally
      doReset();
      timerEnable = 1'b1;
      frames(95 * 30);
      chk("lv_secs4", int'(secondsLeft), 4);
      nextLevel = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("lv_tally", int'(dbgState), int'(ST_TALLY));
      frames(4);
      chk("lv_score", int'(score), 20);
      chk("lv_level", int'(level), 1);
      chk("lv_secs",  int'(secondsLeft), 99);
      chk("lv_start", int'(levelStart), 1);
      step(1'b0, 1'b0, 1'b0);
      chk("lv_start_once", int'(levelStart), 0);
      repeat (5) step(1'b0, 1'b0, 1'b0);
      chk("lv_no_retrigger", int'(level), 1);
      chk("lv_play", int'(dbgState), int'(ST_PLAY));

      // Level 1 -> 2, then finish the last level
      timerEnable = 1'b0;
      nextLevel = 1'b0; step(1'b0, 1'b0, 1'b0);
      nextLevel = 1'b1; step(1'b0, 1'b0, 1'b0);
      frames(99);
      chk("l2_level", int'(level), 2);
      chk("l2_score", int'(score), 515);
      nextLevel = 1'b0; step(1'b0, 1'b0, 1'b0);
      nextLevel = 1'b1; step(1'b0, 1'b0, 1'b0);
      frames(99);
      chk("won_flag",  int'(gameWon), 1);
      chk("won_state", int'(dbgState), int'(ST_WON));
      chk("won_score", int'(score), 1010);
`ifdef GAME_STATUS_BONUS_LIFE_EN
      expLivesWon = 4;
`else
      expLivesWon = 3;
`endif
      repeat (3) step(1'b1, 1'b1, 1'b1);
      nextLevel = 1'b0; step(1'b0, 1'b0, 1'b0);
      nextLevel = 1'b1; step(1'b1, 1'b1, 1'b1);
      chk("won_frozen_score", int'(score), 1010);
      chk("won_frozen_lives", int'(remainingLives), expLivesWon);
      chk("won_frozen_secs",  int'(secondsLeft), 0);
      chk("won_frozen_level", int'(level), 2);
      nextLevel = 1'b0;
      doReset();
      chk("won_rst_lives", int'(remainingLives), 3);
      chk("won_rst_score", int'(score), 0);
      chk("won_rst_level", int'(level), 0);
      chk("won_rst_secs",  int'(secondsLeft), 99);
      chk("won_rst_flag",  int'(gameWon), 0);

      // Game over, outranking a coincident nextLevel edge
      timerEnable = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("ov_lives1", int'(remainingLives), 1);
      frames(10);
      nextLevel = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      chk("ov_lives0", int'(remainingLives), 0);
      chk("ov_flag",   int'(gameOver), 1);
      chk("ov_state",  int'(dbgState), int'(ST_OVER));
      frames(40);
      step(1'b0, 1'b1, 1'b1);
      nextLevel = 1'b0; step(1'b0, 1'b0, 1'b0);
      nextLevel = 1'b1; step(1'b0, 1'b0, 1'b0);
      chk("ov_frozen_secs",  int'(secondsLeft), 99);
      chk("ov_frozen_score", int'(score), 0);
      chk("ov_frozen_lives", int'(remainingLives), 0);
      chk("ov_timeUp",       int'(timeUp), 0);
      chk("ov_state_hold",   int'(dbgState), int'(ST_OVER));

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
